// File: rtl/lsu_mem.sv
// Load/store unit bridging a single core request port to a synchronous RAM.
// Sub-word stores are done as read-modify-write; misaligned requests complete with an error.
module lsu_mem #(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_w_en_o,
    output logic [RAM_AW-1:0] ram_w_addr_o,
    output logic [31:0]       ram_w_data_o,
    output logic              ram_r_en_o,
    output logic [RAM_AW-1:0] ram_r_addr_o,
    input  logic [31:0]       ram_r_data_i
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t              state_reg, state_next;
    logic                we_reg, uns_reg, err_reg;
    logic [1:0]          size_reg;
    logic [RAM_AW+1:0]   addr_reg;
    logic [31:0]         wdata_reg, rdata_reg;
    logic                accept, misaligned;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_data, merged;

    // Address bits above the RAM window are deliberately dropped (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr_i[31:RAM_AW+2]};

    assign req_ready_o = (state_reg == IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;
    assign misaligned  = (req_size_i == 2'b11) ||
                         (req_size_i == 2'b01 && req_addr_i[0]) ||
                         (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg    <= req_we_i;
                uns_reg   <= req_unsigned_i;
                err_reg   <= misaligned;
                size_reg  <= req_size_i;
                addr_reg  <= req_addr_i[RAM_AW+1:0];
                wdata_reg <= req_wdata_i;
            end
            if (state_reg == WAIT) begin
                rdata_reg <= ram_r_data_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misaligned)
                        state_next = RESP;
                    else if (req_we_i && req_size_i == 2'b10)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = WAIT;
            WAIT:    state_next = we_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        ld_byte = rdata_reg[{addr_reg[1:0], 3'b000} +: 8];
        ld_half = rdata_reg[{addr_reg[1], 4'b0000} +: 16];
        case (size_reg)
            2'b00:   ld_data = {{24{~uns_reg & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~uns_reg & ld_half[15]}}, ld_half};
            default: ld_data = rdata_reg;
        endcase
    end

    // Store merge: each byte lane takes new data only if it is the addressed lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [1:0] LANE = 2'(gi);
            assign merged[8*gi +: 8] =
                (size_reg == 2'b00 && addr_reg[1:0] == LANE) ? wdata_reg[7:0] :
                (size_reg == 2'b01 && addr_reg[1] == LANE[1]) ? wdata_reg[8*LANE[0] +: 8] :
                rdata_reg[8*gi +: 8];
        end
    endgenerate

    assign ram_r_en_o   = (state_reg == RD);
    assign ram_w_en_o   = (state_reg == WR);
    assign ram_r_addr_o = addr_reg[RAM_AW+1:2];
    assign ram_w_addr_o = addr_reg[RAM_AW+1:2];
    assign ram_w_data_o = (size_reg == 2'b10) ? wdata_reg : merged;

    assign resp_valid_o = (state_reg == RESP);
    assign resp_err_o   = (state_reg == RESP) && err_reg;
    assign resp_rdata_o = (state_reg == RESP && !we_reg && !err_reg) ? ld_data : 32'h0;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: a behavioural synchronous RAM plus hand-computed vectors.
module tb_lsu_mem;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0]   req_addr_i, req_wdata_i;
    logic [1:0]    req_size_i;
    logic          resp_valid_o, resp_err_o;
    logic [31:0]   resp_rdata_o;
    logic          ram_w_en_o, ram_r_en_o;
    logic [AW-1:0] ram_w_addr_o, ram_r_addr_o;
    logic [31:0]   ram_w_data_o, ram_r_data_i;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem #(.RAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .ram_w_en_o(ram_w_en_o), .ram_w_addr_o(ram_w_addr_o), .ram_w_data_o(ram_w_data_o),
        .ram_r_en_o(ram_r_en_o), .ram_r_addr_o(ram_r_addr_o), .ram_r_data_i(ram_r_data_i)
    );

    always @(posedge clk) begin
        if (ram_w_en_o) mem[ram_w_addr_o] <= ram_w_data_o;
        if (ram_r_en_o) ram_r_data_i <= mem[ram_r_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; exp_rcyc/exp_wcyc = cycle after acceptance of the RAM enable, 0 = none.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input int exp_lat, input int exp_rcyc, input int exp_wcyc,
                          input logic [31:0] exp_ra, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat = 0, rc = 0, wc = 0, rcyc = 0, wcyc = 0;
        logic [31:0] raddr = 0, waddr = 0, wdat = 0, rdat = 0;
        logic err = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_wdata_i = wdata; req_size_i = size; req_unsigned_i = uns;
        check({tag, ":ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = ~addr;
        req_wdata_i = ~wdata; req_size_i = ~size; req_unsigned_i = ~uns;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (ram_r_en_o) begin rc++; rcyc = c; raddr = 32'(ram_r_addr_o); end
            if (ram_w_en_o) begin wc++; wcyc = c; waddr = 32'(ram_w_addr_o); wdat = ram_w_data_o; end
            if (resp_valid_o) begin lat = c; rdat = resp_rdata_o; err = resp_err_o; end
        end
        $display("txn %s we=%0d addr=%h size=%0d lat=%0d rdata=%h err=%0d rd=%0d wr=%0d",
                 tag, we, addr, size, lat, rdat, err, rc, wc);
        check({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ":rdata"}, rdat, exp_rdata);
        check({tag, ":err"}, 32'(err), 32'(exp_err));
        check({tag, ":rd_cnt"}, 32'(rc), (exp_rcyc != 0) ? 32'd1 : 32'd0);
        check({tag, ":wr_cnt"}, 32'(wc), (exp_wcyc != 0) ? 32'd1 : 32'd0);
        if (exp_rcyc != 0) begin
            check({tag, ":rd_cyc"}, 32'(rcyc), 32'(exp_rcyc));
            check({tag, ":rd_addr"}, raddr, exp_ra);
        end
        if (exp_wcyc != 0) begin
            check({tag, ":wr_cyc"}, 32'(wcyc), 32'(exp_wcyc));
            check({tag, ":wr_addr"}, waddr, exp_ra);
            check({tag, ":wr_data"}, wdat, exp_wdata);
        end
    endtask

    initial begin
        int wcount, rvcount;
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0;
        req_wdata_i = 32'h0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:ready", 32'(req_ready_o), 32'd0);
        check("rst:resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst:resp_err", 32'(resp_err_o), 32'd0);
        check("rst:resp_rdata", resp_rdata_o, 32'h0);
        check("rst:enables", {30'd0, ram_w_en_o, ram_r_en_o}, 32'd0);
        check("rst:w_addr", 32'(ram_w_addr_o), 32'd0);
        check("rst:r_addr", 32'(ram_r_addr_o), 32'd0);
        check("rst:w_data", ram_w_data_o, 32'h0);
        rst = 1'b0;
        #1;
        check("rel:ready", 32'(req_ready_o), 32'd1);

        //      tag    we    addr          wdata         sz     u   lat rc wc ra  exp_wdata     exp_rdata     err
        do_req("sw0",  1'b1, 32'h0000_0010, 32'hDEADBEEF, 2'b10, 1'b0, 2, 0, 1, 4, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("sb0",  1'b1, 32'h0000_0012, 32'h0000_0055, 2'b00, 1'b0, 4, 1, 3, 4, 32'hDE55BEEF, 32'h0, 1'b0);
        do_req("sw1",  1'b1, 32'h0000_0010, 32'hDEADBEEF, 2'b10, 1'b0, 2, 0, 1, 4, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lb",   1'b0, 32'h0000_0011, 32'h0,        2'b00, 1'b0, 3, 1, 0, 4, 32'h0, 32'hFFFFFFBE, 1'b0);
        do_req("lbu",  1'b0, 32'h0000_0011, 32'h0,        2'b00, 1'b1, 3, 1, 0, 4, 32'h0, 32'h000000BE, 1'b0);
        do_req("lh",   1'b0, 32'h0000_0012, 32'h0,        2'b01, 1'b0, 3, 1, 0, 4, 32'h0, 32'hFFFFDEAD, 1'b0);
        do_req("lhu",  1'b0, 32'h0000_0012, 32'h0,        2'b01, 1'b1, 3, 1, 0, 4, 32'h0, 32'h0000DEAD, 1'b0);
        do_req("lw",   1'b0, 32'h0000_0010, 32'h0,        2'b10, 1'b0, 3, 1, 0, 4, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("lb3",  1'b0, 32'h0000_0013, 32'h0,        2'b00, 1'b0, 3, 1, 0, 4, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req("lbu0", 1'b0, 32'h0000_0010, 32'h0,        2'b00, 1'b1, 3, 1, 0, 4, 32'h0, 32'h000000EF, 1'b0);
        do_req("lh0",  1'b0, 32'h0000_0010, 32'h0,        2'b01, 1'b0, 3, 1, 0, 4, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("mis_lh", 1'b0, 32'h0000_0013, 32'h0,      2'b01, 1'b0, 1, 0, 0, 0, 32'h0, 32'h0, 1'b1);
        do_req("mis_sw", 1'b1, 32'h0000_0016, 32'h1234,   2'b10, 1'b0, 1, 0, 0, 0, 32'h0, 32'h0, 1'b1);
        do_req("rsv_sz", 1'b0, 32'h0000_0010, 32'h0,      2'b11, 1'b0, 1, 0, 0, 0, 32'h0, 32'h0, 1'b1);
        do_req("wrap_lw", 1'b0, 32'h0000_4010, 32'h0,     2'b10, 1'b0, 3, 1, 0, 4, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("sh_hi", 1'b1, 32'h0000_4012, 32'hFFFF_1234, 2'b01, 1'b0, 4, 1, 3, 4, 32'h1234BEEF, 32'h0, 1'b0);
        do_req("sb_lo", 1'b1, 32'h0000_0010, 32'h0000_AA77, 2'b00, 1'b0, 4, 1, 3, 4, 32'h1234BE77, 32'h0, 1'b0);
        do_req("lw2",  1'b0, 32'h0000_0010, 32'h0,        2'b10, 1'b0, 3, 1, 0, 4, 32'h0, 32'h1234BE77, 1'b0);

        // Reset while a byte store sits in WAIT must drop the pending write.
        wcount = 0; rvcount = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0000_0010;
        req_wdata_i = 32'h0000_0011; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        check("abort:rd_en", 32'(ram_r_en_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort:ready_in_rst", 32'(req_ready_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ram_w_en_o) wcount++;
            if (resp_valid_o) rvcount++;
        end
        rst = 1'b0;
        #1;
        check("abort:ready_after", 32'(req_ready_o), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ram_w_en_o) wcount++;
            if (resp_valid_o) rvcount++;
        end
        $display("txn abort wr_pulses=%0d resp_pulses=%0d", wcount, rvcount);
        check("abort:wr_pulses", 32'(wcount), 32'd0);
        check("abort:resp_pulses", 32'(rvcount), 32'd0);
        do_req("lw3",  1'b0, 32'h0000_0010, 32'h0,        2'b10, 1'b0, 3, 1, 0, 4, 32'h0, 32'h1234BE77, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, RAM word-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  1  core memory request valid.
REQ-005 SHALL have port req_ready_o  output  1  block can accept a request.
REQ-006 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr_i  input  32  byte address.
REQ-008 SHALL have port req_wdata_i  input  32  store data, right-aligned.
REQ-009 SHALL have port req_size_i  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-010 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port resp_valid_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata_o  output  32  load result.
REQ-013 SHALL have port resp_err_o  output  1  misaligned or reserved-size request.
REQ-014 SHALL have ports ram_w_en_o  output  1, ram_w_addr_o  output  RAM_AW, ram_w_data_o  output  32  RAM write port.
REQ-015 SHALL have ports ram_r_en_o  output  1, ram_r_addr_o  output  RAM_AW, ram_r_data_i  input  32  RAM read port.

Function
REQ-016 SHALL accept a request on the rising edge where req_valid_i and req_ready_o are both 1; that edge is cycle N.
REQ-017 SHALL drive req_ready_o to 1 only in state IDLE.
REQ-018 SHALL capture all req_* inputs at acceptance; input changes after acceptance SHALL have no effect on the operation.
REQ-019 SHALL implement FSM states IDLE, RD, WAIT, WR and RESP.
REQ-020 SHALL form the RAM word address as addr[RAM_AW+1:2]; higher address bits are ignored, so addresses wrap.
REQ-021 SHALL treat the RAM as synchronous-write; read data is valid on ram_r_data_i in the cycle after ram_r_en_o is high.
REQ-022 SHALL detect misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-023 On misalignment: IDLE->RESP; resp_valid_o=1 and resp_err_o=1 in cycle N+1; resp_rdata_o=0; no RAM enable asserted.
REQ-024 Load: IDLE->RD (ram_r_en_o=1, cycle N+1) ->WAIT (data sampled, cycle N+2) ->RESP (resp_valid_o=1, cycle N+3).
REQ-025 Load extraction: byte lane = addr[1:0], half lane = addr[1]; the selected lane is sign- or zero-extended to 32 bits per req_unsigned_i.
REQ-026 Word store: IDLE->WR (ram_w_en_o=1, data = wdata, cycle N+1) ->RESP (cycle N+2); no read is issued.
REQ-027 Sub-word store (read-modify-write): IDLE->RD (N+1) ->WAIT (N+2) ->WR (N+3) ->RESP (N+4).
REQ-028 Sub-word merge: only the addressed byte or half is replaced with wdata[7:0] or wdata[15:0]; all other bytes retain the read value.
REQ-029 RESP SHALL last exactly one cycle then return to IDLE; the response SHALL NOT be backpressured.
REQ-030 ram_r_en_o SHALL be high only in RD, and ram_w_en_o only in WR, each for exactly one cycle per request.
REQ-031 RAM addresses SHALL be held stable from RD through WR.
REQ-032 resp_rdata_o SHALL be 0 for stores; resp_err_o SHALL be 0 except as required by REQ-023.
REQ-033 A new request SHALL be accepted no earlier than the cycle after RESP (IDLE), giving back-to-back throughput of one request per 2/3/4/5 cycles.

Reset
REQ-034 While rst=1: state=IDLE and req_ready_o=0.
REQ-035 While rst=1: resp_valid_o, resp_err_o, resp_rdata_o, ram_w_en_o and ram_r_en_o SHALL all be 0.
REQ-036 While rst=1: ram_w_addr_o, ram_r_addr_o and ram_w_data_o SHALL all be 0.
REQ-037 Reset asserted mid-operation (any state) SHALL abort the operation immediately: no RAM write issued and no response produced.
REQ-038 req_ready_o SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-039 Word store addr=0x0000_0010 data=0xDEADBEEF -> ram_w_en_o=1 with w_addr=4, w_data=0xDEADBEEF at N+1; resp_valid_o=1 at N+2.
REQ-040 RAM word 4 = 0xDEADBEEF, byte store addr=0x12 data=0x55 -> read at N+1, write 0xDE55BEEF at N+3, resp at N+4.
REQ-041 Loads from word 0xDEADBEEF: lb addr=0x11 -> 0xFFFFFFBE; lbu -> 0x000000BE; lh addr=0x12 -> 0xFFFFDEAD; lw -> 0xDEADBEEF; each resp at N+3.
REQ-042 Half load addr=0x13 and word store addr=0x16 -> resp_err_o=1 at N+1, no RAM enables asserted.
REQ-043 Address 0x0000_4010 with RAM_AW=12 -> RAM address 4 (wrap).
REQ-044 rst pulsed while the FSM is in WAIT of a byte store -> no ram_w_en_o pulse, no resp_valid_o, req_ready_o=1 after release.
